// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame width and the default bit timing
// (100 MHz / 115200) used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input; flops reset to 1
// so an idle-high line never looks active while reset is asserted.
module uart_sync
  import uart_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, stop-bit check and one-cycle strobes.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_t          state, state_next;
  logic                 rx_s;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_tick, mid_start;
  logic                 cnt_clear, shift_en, set_valid, set_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_en, set_perr;
`endif

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign bit_tick  = (clk_cnt == CNT_LAST);
  assign mid_start = (clk_cnt == CNT_MID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (mid_start) state_next = rx_s ? IDLE : DATA;
      DATA:
        if (bit_tick && bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_tick) state_next = STOP;
`endif
      STOP:  if (bit_tick) state_next = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_clear = 1'b0;
    shift_en  = 1'b0;
    set_valid = 1'b0;
    set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
    set_perr  = 1'b0;
`endif
    busy      = (state != IDLE);
    case (state)
      IDLE, BREAK: cnt_clear = 1'b1;
      START:       cnt_clear = mid_start;
      DATA:        shift_en  = bit_tick;
`ifdef UART_RX_PARITY_EN
      PARITY:      par_en    = bit_tick;
`endif
      STOP:
        if (bit_tick) begin
          if (!rx_s) set_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bit != ^shreg) set_perr = 1'b1;
`endif
          else set_valid = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_cnt    <= (cnt_clear || bit_tick) ? '0 : clk_cnt + 1'b1;
      if (state != DATA) bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      if (shift_en) shreg[bit_idx] <= rx_s;
      if (set_valid) data <= shreg;
      data_valid <= set_valid;
      frame_err  <= set_ferr;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= rx_s;
      parity_err <= set_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit, 2 sync stages.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = (19 * CPB) / 2 + SYNC + 1 + CPB;
`else
  localparam int LAT  = (19 * CPB) / 2 + SYNC + 1;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       data_valid, frame_err, parity_err, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_dv_cyc = 0;
  int dv_count = 0;
  int fe_count = 0;
  int pe_count = 0;
  int pulse_viol = 0;
  logic prev_dv = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0;
  logic [7:0] dv_hist [0:31];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: counts strobes, logs delivered bytes, flags overlapping or stretched pulses.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (dv_count < 32) dv_hist[dv_count] = data;
      dv_count++;
      last_dv_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_count++;
    if (parity_err === 1'b1) pe_count++;
    if ((data_valid === 1'b1 && prev_dv) || (frame_err === 1'b1 && prev_fe) ||
        (parity_err === 1'b1 && prev_pe))
      pulse_viol++;
    if (int'(data_valid === 1'b1) + int'(frame_err === 1'b1) + int'(parity_err === 1'b1) > 1)
      pulse_viol++;
    prev_dv = (data_valid === 1'b1);
    prev_fe = (frame_err === 1'b1);
    prev_pe = (parity_err === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitBit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one full frame; rx is left at the stop level so a low stop can be stretched.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    start_cyc = cyc;
    waitBit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitBit();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    waitBit();
`endif
    rx = stop_val;
    waitBit();
  endtask

  initial begin
    int dv0, fe0;
    logic [7:0] partial;

    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_data", data, 8'h00);
    checkOutput("reset_valid", data_valid, 1'b0);
    checkOutput("reset_ferr", frame_err, 1'b0);
    checkOutput("reset_perr", parity_err, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(20);

    dv0 = dv_count;
    applyStimulus(8'hA5, 1'b1);
    idle(20);
    checkOutput("a5_count", dv_count, dv0 + 1);
    checkOutput("a5_data", data, 8'hA5);
    checkOutput("a5_ferr", fe_count, 0);
    checkOutput("a5_latency_ok", (last_dv_cyc - start_cyc >= LAT - 1) &&
                                 (last_dv_cyc - start_cyc <= LAT + 1), 1'b1);
    checkOutput("a5_busy", busy, 1'b0);

    dv0 = dv_count;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    idle(20);
    checkOutput("b2b_count", dv_count, dv0 + 2);
    checkOutput("b2b_first", dv_hist[dv0], 8'h00);
    checkOutput("b2b_second", dv_hist[dv0 + 1], 8'hFF);
    checkOutput("b2b_data", data, 8'hFF);

    dv0 = dv_count;
    fe0 = fe_count;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    @(negedge clk);
    checkOutput("glitch_busy_high", busy, 1'b1);
    idle(20);
    checkOutput("glitch_busy_low", busy, 1'b0);
    checkOutput("glitch_no_valid", dv_count, dv0);
    checkOutput("glitch_no_ferr", fe_count, fe0);

    applyStimulus(8'h3C, 1'b0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    checkOutput("ferr_pulse", fe_count, fe0 + 1);
    checkOutput("ferr_no_valid", dv_count, dv0);
    checkOutput("ferr_data_kept", data, 8'hFF);
    checkOutput("ferr_busy_hold", busy, 1'b1);
    idle(20);
    checkOutput("ferr_busy_release", busy, 1'b0);
    checkOutput("ferr_no_retrigger", fe_count, fe0 + 1);
    checkOutput("ferr_no_valid_after", dv_count, dv0);

    partial = 8'h81;
    rx = 1'b0;
    waitBit();
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      waitBit();
    end
    rx = partial[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_data", data, 8'h00);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    checkOutput("midrst_no_valid", dv_count, dv0);
    applyStimulus(8'h42, 1'b1);
    idle(20);
    checkOutput("after_rst_count", dv_count, dv0 + 1);
    checkOutput("after_rst_data", data, 8'h42);
    checkOutput("after_rst_ferr", fe_count, fe0 + 1);

`ifdef UART_RX_PARITY_EN
    dv0 = dv_count;
    par_flip = 1'b0;
    applyStimulus(8'h07, 1'b1);
    idle(20);
    checkOutput("par_ok_count", dv_count, dv0 + 1);
    checkOutput("par_ok_data", data, 8'h07);
    checkOutput("par_ok_perr", pe_count, 0);
    par_flip = 1'b1;
    applyStimulus(8'h07, 1'b1);
    idle(20);
    checkOutput("par_bad_perr", pe_count, 1);
    checkOutput("par_bad_no_valid", dv_count, dv0 + 1);
    checkOutput("par_bad_data", data, 8'h07);
`else
    checkOutput("perr_never", pe_count, 0);
`endif

    checkOutput("pulse_shape", pulse_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the same 8N1 UART link that the team's transmitter drives. The line idles high.
- Samples the asynchronous rx pin, finds the start bit, and samples each data bit at mid-bit. It validates the stop bit and delivers each byte with a one-cycle valid strobe.
- Sits between the board rx pin and the byte consumer, such as a command decoder or an echo back to the transmitter.

Parameters:
- CLKS_PER_BIT, default 868: clk cycles per bit (100 MHz / 115200). Must be ≥ 4.
- SYNC_STAGES, default 2: flop depth of the rx input synchronizer. Must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset, released synchronously by the system.
- rx  in  1  serial input, asynchronous to clk, idle high.
- data  out  8  last correctly received byte; held until the next good frame.
- data_valid  out  1  one-cycle pulse; data is new on this cycle.
- frame_err  out  1  one-cycle pulse; the stop bit was sampled low.
- parity_err  out  1  one-cycle pulse (UART_RX_PARITY_EN only); tied 0 otherwise.
- busy  out  1  high from start-bit acceptance until the frame completes or aborts.

Behaviour:
- Reset values (asynchronous):
  - data = 8'h00; data_valid = 0; frame_err = 0; parity_err = 0; busy = 0.
  - State = IDLE; synchronizer flops = 1; bit counter and clock counter = 0.
- Synchronizer: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Counter: clk_cnt counts 0..CLKS_PER_BIT-1. A "bit tick" occurs when clk_cnt wraps.
- State machine:
  - IDLE:
    - rx_s == 0 → START, clk_cnt = 0, busy = 1.
  - START:
    - Wait until clk_cnt == CLKS_PER_BIT/2 - 1 (integer division), then re-sample rx_s.
    - rx_s == 0 → DATA, clk_cnt = 0, bit_idx = 0.
    - rx_s == 1 → false start (glitch): go to IDLE, busy = 0, no pulses.
  - DATA:
    - On each bit tick, shift rx_s into the shift register LSB-first: shreg[bit_idx] = rx_s.
    - After bit_idx == 7 → PARITY if the feature is enabled, else STOP.
  - STOP:
    - On the bit tick, sample rx_s (this is mid-stop-bit).
    - rx_s == 1 → data = shreg, pulse data_valid, busy = 0, go to IDLE.
    - rx_s == 0 → pulse frame_err; data is unchanged; go to BREAK.
  - BREAK:
    - Stay until rx_s == 1 for one cycle, then go to IDLE with busy = 0.
    - This prevents a held-low line from re-triggering a start bit.
- Timing:
  - Returning to IDLE at mid-stop lets back-to-back frames, with zero idle time between them, be received without loss.
  - data_valid asserts 9.5*CLKS_PER_BIT + SYNC_STAGES + 1 (±1) clk after the start-bit falling edge on rx.
- Pulses: data_valid, frame_err and parity_err are never high together and never last longer than 1 cycle.
- Reset mid-frame: return immediately to the reset values. The partial byte is discarded and no pulse is issued.
- No backpressure: the consumer must take data on data_valid. A later frame overwrites data.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It samples one bit on the bit tick.
  - Expected parity is even: ^shreg.
  - On mismatch: pulse parity_err in the STOP-sample cycle instead of data_valid; data is unchanged.
  - frame_err takes priority over parity_err.
  - Latency grows by CLKS_PER_BIT.
- Undefined: 8N1 only; parity_err is constant 0.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - DATA_BITS = 8;
  - default CLKS_PER_BIT constant, shared with the transmitter.
- One sub-module: uart_sync, a parameterised SYNC_STAGES-flop synchronizer with reset value 1, reusable by other async inputs.

Test Plan (CLKS_PER_BIT = 16, SYNC_STAGES = 2):
- Idle line, then frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → data_valid once, data = 8'hA5, frame_err = 0, latency 155 ±1 clk from the start edge.
- Two back-to-back frames 0x00 then 0xFF with no idle gap → two data_valid pulses, data 8'h00 then 8'hFF.
- rx low glitch of 5 clk in IDLE → busy pulses briefly, then returns to 0; no data_valid and no frame_err.
- Frame 0x3C with the stop bit held low for 3 bit times → frame_err pulses once, data keeps its previous value, no new frame until rx returns high.
- rst_n asserted during bit 4 of frame 0x81, released, then frame 0x42 sent → no pulse for 0x81; data = 8'h42 with data_valid.
- UART_RX_PARITY_EN defined: 0x07 with parity bit 1 → data_valid; 0x07 with parity bit 0 → parity_err, data unchanged.
